// File: rtl/mem_bus_ctrl.sv
// Purpose: bridges core load/store requests onto a word-wide memory port with lane steering and load extension.
// Latency: request sampled at edge N, mem_req in cycle N+1, mem_response in cycle N+2 when mem_ready is high.
// Backpressure: waits in ACCESS on mem_ready up to TIMEOUT cycles; holds in RELEASE until the core drops its request.
module mem_bus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        mem_response,
  output logic [31:0] read_data,
  output logic        mem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  // Counter wide enough to hold the value TIMEOUT itself.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] OPT_B  = 3'b000;
  localparam logic [2:0] OPT_H  = 3'b001;
  localparam logic [2:0] OPT_W  = 3'b010;
  localparam logic [2:0] OPT_BU = 3'b100;
  localparam logic [2:0] OPT_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   tcnt;
  logic [CW-1:0]   tcnt_nxt;
  logic [2:0]      opt_q;
  logic [1:0]      off_q;

  logic            req_bad;
  logic [31:0]     st_wdata;
  logic [3:0]      st_be;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_value;

  assign tcnt_nxt = tcnt + 1'b1;

  // Classify the incoming request: undefined option or misaligned address is rejected without a memory access.
  always_comb begin
    req_bad = 1'b0;
    case (option)
      OPT_B, OPT_BU: req_bad = 1'b0;
      OPT_H, OPT_HU: req_bad = address[0];
      OPT_W:         req_bad = (address[1:0] != 2'b00);
      default:       req_bad = 1'b1;
    endcase
  end

  // Replicate store data across lanes and pick the byte enables from the low address bits.
  always_comb begin
    st_wdata = write_data;
    st_be    = 4'b1111;
    case (option[1:0])
      2'b00: begin
        st_wdata = {4{write_data[7:0]}};
        st_be    = 4'b0001 << address[1:0];
      end
      2'b01: begin
        st_wdata = {2{write_data[15:0]}};
        st_be    = address[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = write_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Pull the addressed byte/halfword out of the returned word and extend it per the latched access type.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_value = mem_rdata;
    case (opt_q)
      OPT_B:   ld_value = {{24{ld_byte[7]}}, ld_byte};
      OPT_BU:  ld_value = {24'd0, ld_byte};
      OPT_H:   ld_value = {{16{ld_half[15]}}, ld_half};
      OPT_HU:  ld_value = {16'd0, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  // Request FSM; every core- and memory-facing output is a flop so reset clears them without an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      tcnt         <= '0;
      opt_q        <= 3'b000;
      off_q        <= 2'b00;
      mem_response <= 1'b0;
      mem_error    <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= 4'b0000;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      read_data    <= 32'd0;
    end else begin
      mem_response <= 1'b0;
      mem_error    <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            opt_q     <= option;
            off_q     <= address[1:0];
            mem_addr  <= {address[31:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_be    <= st_be;
            tcnt      <= '0;
            if (req_bad) begin
              state        <= RESP;
              mem_response <= 1'b1;
              mem_error    <= 1'b1;
            end else begin
              state   <= ACCESS;
              mem_req <= 1'b1;
              // Store wins when the core raises both strobes.
              mem_we  <= mem_write;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            state        <= RESP;
            mem_response <= 1'b1;
            if (!mem_we) begin
              read_data <= ld_value;
            end
          end else if (tcnt_nxt == CW'(TIMEOUT)) begin
            tcnt         <= tcnt_nxt;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            state        <= RESP;
            mem_response <= 1'b1;
            mem_error    <= 1'b1;
          end else begin
            tcnt <= tcnt_nxt;
          end
        end
        RESP: begin
          state <= RELEASE;
        end
        RELEASE: begin
          // The core keeps its strobe up until it sees the response; wait for it to let go.
          if (!mem_read && !mem_write) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a response scoreboard.
// Expected responses are queued at request time and popped when mem_response fires.
// Memory side is modelled by driving mem_ready/mem_rdata directly.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        resetn;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  option;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_response;
  logic [31:0] read_data;
  logic        mem_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int vectors     = 0;
  int miscompares = 0;
  int req_total   = 0;
  int resp_total  = 0;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .option       (option),
    .address      (address),
    .write_data   (write_data),
    .mem_response (mem_response),
    .read_data    (read_data),
    .mem_error    (mem_error),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Count memory-request and response cycles; a write strobe must never appear without a request.
  always @(negedge clk) begin
    if (mem_req === 1'b1) req_total++;
    if (mem_response === 1'b1) resp_total++;
    if (mem_req !== 1'b1) check("we_without_req", 32'(mem_we), 32'd0);
  end

  task automatic run_req(input string tag, input logic rd, input logic wr, input logic [2:0] opt,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                         input int exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input int hold);
    int   cyc;
    bit   got;
    int   r0;
    int   s0;
    exp_t e;
    r0 = req_total;
    s0 = resp_total;
    mem_read   = rd;
    mem_write  = wr;
    option     = opt;
    address    = addr;
    write_data = wd;
    e.err = exp_err;
    e.rd  = exp_rd;
    sb.push_back(e);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1 && exp_req > 0) begin
        check({tag, "/req"},  32'(mem_req), 32'd1);
        check({tag, "/we"},   32'(mem_we), 32'(wr));
        check({tag, "/addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "/be"},   32'(mem_be), 32'(exp_be));
        if (wr) check({tag, "/wdata"}, mem_wdata, exp_wdata);
        // Disturb the request inputs; the latched access must be unaffected.
        address    = ~addr;
        write_data = ~wd;
        option     = 3'b011;
      end
      if (mem_response === 1'b1) got = 1'b1;
    end
    check({tag, "/resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "/err"}, 32'(mem_error), 32'(e.err));
        check({tag, "/rdata"}, read_data, e.rd);
      end
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    repeat (hold) @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "/req_cycles"}, 32'(req_total - r0), 32'(exp_req));
    check({tag, "/resp_count"}, 32'(resp_total - s0), 32'd1);
  endtask

  initial begin
    resetn     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    option     = 3'b000;
    address    = 32'd0;
    write_data = 32'd0;
    mem_ready  = 1'b1;
    mem_rdata  = 32'd0;

    #12;
    check("rst/response", 32'(mem_response), 32'd0);
    check("rst/error",    32'(mem_error), 32'd0);
    check("rst/req",      32'(mem_req), 32'd0);
    check("rst/we",       32'(mem_we), 32'd0);
    check("rst/be",       32'(mem_be), 32'd0);
    check("rst/addr",     mem_addr, 32'd0);
    check("rst/wdata",    mem_wdata, 32'd0);
    check("rst/rdata",    read_data, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    mem_ready = 1'b1;
    mem_rdata = 32'h80FF_1234;
    //      tag          rd    wr    opt     addr          wd            err   exp_rd          lat req be       wdata         hold
    run_req("lb_103",    1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,       1'b0, 32'hFFFF_FF80, 2,  1,  4'b1000, 32'h0,        0);
    run_req("sh_22",     1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 1'b0, 32'hFFFF_FF80, 2,  1,  4'b1100, 32'hABCD_ABCD, 3);
    run_req("lw_mis",    1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,       1'b1, 32'hFFFF_FF80, 1,  0,  4'b0000, 32'h0,        0);
    mem_rdata = 32'h1234_5678;
    run_req("lw_hold",   1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,       1'b0, 32'h1234_5678, 2,  1,  4'b1111, 32'h0,        3);
    mem_rdata = 32'h80FF_1234;
    run_req("lh_102",    1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,       1'b0, 32'hFFFF_80FF, 2,  1,  4'b1100, 32'h0,        0);
    run_req("lhu_102",   1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,       1'b0, 32'h0000_80FF, 2,  1,  4'b1100, 32'h0,        0);
    run_req("lbu_101",   1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,       1'b0, 32'h0000_0012, 2,  1,  4'b0010, 32'h0,        0);
    run_req("lb_102",    1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,       1'b0, 32'hFFFF_FFFF, 2,  1,  4'b0100, 32'h0,        0);
    run_req("bad_opt",   1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,       1'b1, 32'hFFFF_FFFF, 1,  0,  4'b0000, 32'h0,        0);
    run_req("lh_mis",    1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,       1'b1, 32'hFFFF_FFFF, 1,  0,  4'b0000, 32'h0,        0);
    mem_ready = 1'b0;
    run_req("timeout",   1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,       1'b1, 32'hFFFF_FFFF, 5,  4,  4'b1111, 32'h0,        0);
    mem_ready = 1'b1;
    run_req("sb_13",     1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'hFFFF_FF5A, 1'b0, 32'hFFFF_FFFF, 2,  1,  4'b1000, 32'h5A5A_5A5A, 0);
    run_req("rw_both",   1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'hFFFF_FFFF, 2,  1,  4'b1111, 32'hDEAD_BEEF, 0);

    // Reset pulse in the middle of a stalled access.
    mem_ready = 1'b0;
    mem_read  = 1'b1;
    option    = 3'b010;
    address   = 32'h0000_0300;
    repeat (3) @(posedge clk);
    #1;
    check("midrst/req_before", 32'(mem_req), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst/req",      32'(mem_req), 32'd0);
    check("midrst/we",       32'(mem_we), 32'd0);
    check("midrst/be",       32'(mem_be), 32'd0);
    check("midrst/addr",     mem_addr, 32'd0);
    check("midrst/wdata",    mem_wdata, 32'd0);
    check("midrst/rdata",    read_data, 32'd0);
    check("midrst/response", 32'(mem_response), 32'd0);
    check("midrst/error",    32'(mem_error), 32'd0);
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    run_req("post_rst",  1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,       1'b0, 32'hCAFE_0001, 2,  1,  4'b1111, 32'h0,        0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
